fetch_buffer: RTL

Instruction fetch buffer sitting directly downstream of the program-counter/instruction-memory pair and upstream of decode. It captures each fetched instruction together with its PC+2 value into a small FIFO and presents them to decode with a valid/ready handshake. It absorbs instruction-cache miss cycles and decode stalls, and back-pressures the PC when full. It also discards wrong-path instructions on a branch flush and stops accepting fetches after a HALT has been captured.

---
 rtl/cpu_pkg.sv | 20 ++
 rtl/fetch_fifo.sv | 53 +++++
 rtl/fetch_buffer.sv | 102 ++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU constants: instruction width, opcode field location, the HALT
// opcode and the NOP encoding. Used by fetch, decode and PC logic.
package cpu_pkg;

  localparam int INSTR_W    = 16;
  localparam int OPCODE_MSB = 15;
  localparam int OPCODE_LSB = 11;
  localparam int OPCODE_W   = OPCODE_MSB - OPCODE_LSB + 1;

  localparam logic [OPCODE_W-1:0] OP_HALT   = 5'b00000;
  localparam logic [INSTR_W-1:0]  NOP_INSTR = 16'h0800;

  typedef logic [OPCODE_W-1:0] opcode_t;

  // True when the opcode field encodes HALT.
  function automatic logic is_halt(input opcode_t op);
    return op == OP_HALT;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Circular storage for fetched (instruction, PC+2) pairs. Pointers carry one
// extra MSB so a full buffer is distinguishable from an empty one; clear
// returns both pointers to zero and wins over push/pop.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic                     i_clear,
  input  logic [WIDTH-1:0]         i_instr,
  input  logic [WIDTH-1:0]         i_pc2,
  output logic [WIDTH-1:0]         o_instr,
  output logic [WIDTH-1:0]         o_pc2,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [WIDTH-1:0] r_instr_mem [DEPTH];
  logic [WIDTH-1:0] r_pc2_mem   [DEPTH];

  // Pointer update: clear resets both, otherwise push/pop advance independently.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Entry write; payload needs no reset since validity comes from the pointers.
  always_ff @(posedge clk) begin
    if (i_push && !i_clear) begin
      r_instr_mem[r_wr_ptr[AW-1:0]] <= i_instr;
      r_pc2_mem[r_wr_ptr[AW-1:0]]   <= i_pc2;
    end
  end

  assign o_instr = r_instr_mem[r_rd_ptr[AW-1:0]];
  assign o_pc2   = r_pc2_mem[r_rd_ptr[AW-1:0]];
  assign o_count = r_wr_ptr - r_rd_ptr;

endmodule

// File: rtl/fetch_buffer.sv
// Instruction fetch buffer between instruction memory and decode. Wraps
// fetch_fifo with the valid/ready handshakes, sticky HALT capture and branch
// flush. Optional build macro FETCH_BYPASS_EN adds a zero-latency path from
// fetch to decode when the buffer is empty.
module fetch_buffer #(
  parameter int               DEPTH     = 2,
  parameter int               WIDTH     = 16,
  parameter logic [WIDTH-1:0] NOP_INSTR = cpu_pkg::NOP_INSTR
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_instr,
  input  logic [WIDTH-1:0] in_pc2,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_instr,
  output logic [WIDTH-1:0] out_pc2,
  input  logic             out_ready,
  input  logic             flush,
  output logic             halted
);

  import cpu_pkg::*;

  localparam int          AW        = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

  logic [AW:0]      w_count;
  logic [WIDTH-1:0] w_head_instr;
  logic [WIDTH-1:0] w_head_pc2;
  logic             w_in_ready;
  logic             w_stored_valid;
  logic             w_bypass;
  logic             w_push;
  logic             w_pop;
  logic             w_fifo_push;
  logic             w_fifo_pop;
  logic             w_halt_seen;
  logic             r_halted;

  // in_ready depends only on registered state so decode stalls never reach the PC combinationally.
  assign w_in_ready     = (w_count < DEPTH_CNT) & ~r_halted;
  assign w_stored_valid = (w_count != '0);

`ifdef FETCH_BYPASS_EN
  assign w_bypass = ~w_stored_valid & in_valid & out_ready & ~flush & ~r_halted;
`else
  assign w_bypass = 1'b0;
`endif

  assign w_push      = in_valid & w_in_ready & ~flush;
  assign w_pop       = out_valid & out_ready & ~flush;
  assign w_fifo_push = w_push & ~w_bypass;
  assign w_fifo_pop  = w_pop & ~w_bypass;
  assign w_halt_seen = w_push & is_halt(in_instr[OPCODE_MSB:OPCODE_LSB]);

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_fifo_push),
    .i_pop   (w_fifo_pop),
    .i_clear (flush),
    .i_instr (in_instr),
    .i_pc2   (in_pc2),
    .o_instr (w_head_instr),
    .o_pc2   (w_head_pc2),
    .o_count (w_count)
  );

  // Sticky HALT flag: set by an accepted HALT beat, cleared only by flush or reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_halted <= 1'b0;
    end else if (flush) begin
      r_halted <= 1'b0;
    end else if (w_halt_seen) begin
      r_halted <= 1'b1;
    end
  end

  // Output mux: bypassed beat, else buffered head, else a NOP with zero PC.
  always_comb begin
    out_instr = NOP_INSTR;
    out_pc2   = '0;
    if (w_bypass) begin
      out_instr = in_instr;
      out_pc2   = in_pc2;
    end else if (w_stored_valid) begin
      out_instr = w_head_instr;
      out_pc2   = w_head_pc2;
    end
  end

  assign out_valid = w_stored_valid | w_bypass;
  assign in_ready  = w_in_ready;
  assign halted    = r_halted;

endmodule
